// File: rtl/reg_ctx_xfer_if.sv
// Register-file and stream bundle for the context save/restore engine.
// master = engine side, slave = register file plus stream endpoints.
interface reg_ctx_xfer_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic [AW-1:0] rf_wr_sel;
  logic          rf_wr_en;
  logic [DW-1:0] rf_wr_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;

  modport master (
    output rf_rd_addr, input  rf_rd_data,
    output rf_wr_sel,  output rf_wr_en, output rf_wr_data,
    output out_valid,  output out_data, input  out_ready,
    input  in_valid,   input  in_data,  output in_ready
  );

  modport slave (
    input  rf_rd_addr, output rf_rd_data,
    input  rf_wr_sel,  input  rf_wr_en, input  rf_wr_data,
    input  out_valid,  input  out_data, output out_ready,
    output in_valid,   output in_data,  input  in_ready
  );
endinterface

// File: rtl/reg_ctx_xfer.sv
// Context save/restore engine: streams the register file out (save) or in (restore).
// Optional CTX_XFER_SKIP_R0_EN: skip hard-zero register 0 in both directions.
module reg_ctx_xfer #(
  parameter int NREGS = 8,
  parameter int DW    = 16,
  parameter int AW    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            save_req,
  input  logic            restore_req,
  output logic            busy,
  output logic            done,
  reg_ctx_xfer_if.master  bus
);

`ifdef CTX_XFER_SKIP_R0_EN
  localparam logic [AW-1:0] FIRST = AW'(1);
`else
  localparam logic [AW-1:0] FIRST = '0;
`endif
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic [2:0] {
    IDLE, SAVE_RD, SAVE_OUT, RESTORE, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  logic in_save, in_rest;
  assign in_save = (state_q == SAVE_RD) || (state_q == SAVE_OUT);
  assign in_rest = (state_q == RESTORE);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (save_req)         state_d = SAVE_RD;
        else if (restore_req) state_d = RESTORE;
      end
      SAVE_RD: begin
        out_data_d  = bus.rf_rd_data;
        out_valid_d = 1'b1;
        state_d     = SAVE_OUT;
      end
      SAVE_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = SAVE_RD;
          end
        end
      end
      RESTORE: begin
        // The write itself is combinational; only the index advances here.
        if (bus.in_valid) begin
          if (idx_q == LAST) state_d = DONE;
          else               idx_d   = idx_q + AW'(1);
        end
      end
      DONE: begin
        idx_d   = FIRST;
        state_d = IDLE;
      end
      default: begin
        idx_d       = FIRST;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= FIRST;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.rf_rd_addr = in_save ? idx_q : '0;

  // Restore side is gated by state so nothing reaches the RF outside RESTORE.
  assign bus.in_ready   = in_rest;
  assign bus.rf_wr_en   = in_rest & bus.in_valid;
  assign bus.rf_wr_sel  = in_rest ? idx_q : '0;
  assign bus.rf_wr_data = in_rest ? bus.in_data : '0;

endmodule

// File: tb/tb_reg_ctx_xfer.sv
// Bench for reg_ctx_xfer: behavioural RF plus register-content model, random stalls/data.
module tb_reg_ctx_xfer;
  localparam int NREGS = 8;
  localparam int DW    = 16;
  localparam int AW    = 3;
`ifdef CTX_XFER_SKIP_R0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NW = NREGS - FIRST;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic save_req = 1'b0;
  logic restore_req = 1'b0;
  logic busy, done;

  reg_ctx_xfer_if #(.DW(DW), .AW(AW)) bus ();

  reg_ctx_xfer #(.NREGS(NREGS), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Register file stand-in and the expected register contents.
  logic [DW-1:0] rf     [NREGS];
  logic [DW-1:0] pl_val [NREGS];
  logic [DW-1:0] mdl    [NREGS];
  logic          pl_en = 1'b0;

  assign bus.rf_rd_data = rf[bus.rf_rd_addr];

  always @(posedge clk) begin
    if (bus.rf_wr_en) rf[bus.rf_wr_sel] <= bus.rf_wr_data;
    else if (pl_en) for (int i = 0; i < NREGS; i++) rf[i] <= pl_val[i];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_ovld"},  bus.out_valid, 0);
    chk({tag, "_irdy"},  bus.in_ready, 0);
    chk({tag, "_wren"},  bus.rf_wr_en, 0);
    chk({tag, "_rdadr"}, bus.rf_rd_addr, 0);
    chk({tag, "_wrsel"}, bus.rf_wr_sel, 0);
  endtask

  task automatic preload(input int mode);
    for (int i = 0; i < NREGS; i++) begin
      pl_val[i] = (mode == 0) ? DW'(32'h1000 + i) : DW'($urandom);
      mdl[i]    = pl_val[i];
    end
    pl_en = 1'b1;
    step();
    pl_en = 1'b0;
  endtask

  // mode 0: ready always, 1: ready toggling, 2: random. both: restore_req raised too.
  task automatic save_run(input int mode, input bit both, output int dcyc);
    logic [DW-1:0] got[$];
    logic [DW-1:0] held;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    dcyc = -1;
    save_req = 1'b1;
    restore_req = both;
    for (int c = 0; c < 400; c++) begin
      step();
      save_req = 1'b0;
      restore_req = both ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(c % 2) : 1'($urandom_range(0, 1));
      #1;
      chk("save_no_wr", {bus.rf_wr_en, bus.in_ready}, 0);
      if (done) begin
        dcyc = c;
        break;
      end
      if (bus.out_valid) begin
        if (stalled) chk("save_hold", bus.out_data, held);
        stalled = !bus.out_ready;
        held    = bus.out_data;
        if (bus.out_ready) got.push_back(bus.out_data);
      end
    end
    restore_req = 1'b0;
    bus.out_ready = 1'b0;
    chk("save_done_seen", dcyc >= 0, 1);
    chk("save_count", got.size(), NW);
    for (int k = 0; k < got.size() && k < NW; k++) chk("save_word", got[k], mdl[FIRST + k]);
    step();
    #1;
    chk_idle_outs("save_after");
  endtask

  // mode 0: in_valid always with 0xA0A0+i; 1: random valid/data and stray requests.
  task automatic restore_run(input int mode, output int dcyc);
    logic [DW-1:0] q[$];
    int k;
    k = 0;
    dcyc = -1;
    for (int i = 0; i < NW; i++) q.push_back((mode == 0) ? DW'(32'hA0A0 + i) : DW'($urandom));
    restore_req = 1'b1;
    for (int c = 0; c < 400; c++) begin
      step();
      restore_req = (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      save_req    = (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.in_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.in_data  = (k < NW) ? q[k] : DW'($urandom);
      #1;
      if (done) begin
        dcyc = c;
        break;
      end
      chk("rest_ovld", bus.out_valid, 0);
      chk("rest_irdy", bus.in_ready, 1);
      chk("rest_wren", bus.rf_wr_en, bus.in_valid);
      if (bus.in_valid) begin
        chk("rest_sel",  bus.rf_wr_sel, FIRST + k);
        chk("rest_data", bus.rf_wr_data, bus.in_data);
        if (k < NW) mdl[FIRST + k] = q[k];
        k++;
      end
    end
    restore_req = 1'b0;
    save_req = 1'b0;
    bus.in_valid = 1'b0;
    chk("rest_done_seen", dcyc >= 0, 1);
    chk("rest_count", k, NW);
    step();
    #1;
    chk_idle_outs("rest_after");
    for (int i = 0; i < NREGS; i++) chk("rest_rf", rf[i], mdl[i]);
  endtask

  initial begin
    int dc;
    int h;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    #2 rst = 1'b0;
    #20;
    chk_idle_outs("reset");
    chk("reset_odata", bus.out_data, 0);
    @(negedge clk);
    rst = 1'b1;

    // Full save of a known pattern, sink always ready.
    preload(0);
    save_run(0, 1'b0, dc);
    chk("save_done_cycle", dc, 2 * NW);

    // Reset while the 4th word is being offered.
    save_req = 1'b1;
    h = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      save_req = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid) begin
        if (h == 3) break;
        h++;
      end
    end
    chk("midrst_words", h, 3);
    chk("midrst_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk_idle_outs("midrst");
    chk("midrst_odata", bus.out_data, 0);
    bus.out_ready = 1'b0;
    step();
    rst = 1'b1;

    // Next save restarts from the first register.
    save_run(0, 1'b0, dc);
    save_run(1, 1'b0, dc);
    preload(1);
    save_run(2, 1'b0, dc);

    // Restore a known pattern, then save it back verbatim.
    restore_run(0, dc);
    chk("rest_done_cycle", dc, NW);
    save_run(0, 1'b0, dc);

    // Simultaneous requests: save wins, restore_req ignored while busy.
    save_run(2, 1'b1, dc);

    for (int r = 0; r < 3; r++) begin
      restore_run(1, dc);
      save_run(2, 1'b0, dc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
